// File: rtl/cv32e40p_fpu_pkg.sv
// cv32e40p_fpu_pkg: shared widths, defaults and buffer entry/result types for the FPU X-IF buffer
package cv32e40p_fpu_pkg;
  localparam int C_FLEN = 32;
  localparam int C_ID_WIDTH = 4;
  localparam int C_DEPTH = 4;
  localparam int C_MAX_OUTSTANDING = 2;
  typedef logic [3:0] fp_op_t;
  typedef logic [2:0] fp_fmt_t;
  typedef logic [2:0] fp_rm_t;
  typedef struct packed {
    logic [C_ID_WIDTH-1:0] id;
    fp_op_t op;
    logic op_mod;
    fp_fmt_t fmt;
    fp_rm_t rm;
    logic [2:0][C_FLEN-1:0] rs;
    logic committed;
    logic killed;
  } fpu_xif_entry_t;
  typedef struct packed {
    logic [C_ID_WIDTH-1:0] id;
    logic [C_FLEN-1:0] data;
    logic [4:0] fflags;
  } fpu_xif_result_t;
endpackage

// File: rtl/cv32e40p_fpu_xif_buffer_if.sv
// cv32e40p_fpu_xif_buffer_if: X-IF issue/commit/result and FPU request/response bundle
interface cv32e40p_fpu_xif_buffer_if;
  import cv32e40p_fpu_pkg::*;
  logic x_issue_valid;
  logic x_issue_ready;
  logic [C_ID_WIDTH-1:0] x_issue_id;
  fp_op_t x_issue_op;
  logic x_issue_op_mod;
  fp_fmt_t x_issue_fmt;
  fp_rm_t x_issue_rm;
  logic [2:0][C_FLEN-1:0] x_issue_rs;
  logic x_commit_valid;
  logic [C_ID_WIDTH-1:0] x_commit_id;
  logic x_commit_kill;
  logic fpu_req_valid;
  logic fpu_req_ready;
  logic [C_ID_WIDTH-1:0] fpu_req_tag;
  fp_op_t fpu_req_op;
  logic fpu_req_op_mod;
  fp_fmt_t fpu_req_fmt;
  fp_rm_t fpu_req_rm;
  logic [2:0][C_FLEN-1:0] fpu_req_rs;
  logic fpu_rsp_valid;
  logic fpu_rsp_ready;
  logic [C_ID_WIDTH-1:0] fpu_rsp_tag;
  logic [C_FLEN-1:0] fpu_rsp_result;
  logic [4:0] fpu_rsp_fflags;
  logic x_result_valid;
  logic x_result_ready;
  logic [C_ID_WIDTH-1:0] x_result_id;
  logic [C_FLEN-1:0] x_result_data;
  logic [4:0] x_result_fflags;
  logic busy;
  modport slave (
    input x_issue_valid, x_issue_id, x_issue_op, x_issue_op_mod, x_issue_fmt, x_issue_rm, x_issue_rs,
    input x_commit_valid, x_commit_id, x_commit_kill,
    input fpu_req_ready, fpu_rsp_valid, fpu_rsp_tag, fpu_rsp_result, fpu_rsp_fflags, x_result_ready,
    output x_issue_ready, fpu_req_valid, fpu_req_tag, fpu_req_op, fpu_req_op_mod, fpu_req_fmt, fpu_req_rm,
    output fpu_req_rs, fpu_rsp_ready, x_result_valid, x_result_id, x_result_data, x_result_fflags, busy
  );
  modport master (
    output x_issue_valid, x_issue_id, x_issue_op, x_issue_op_mod, x_issue_fmt, x_issue_rm, x_issue_rs,
    output x_commit_valid, x_commit_id, x_commit_kill,
    output fpu_req_ready, fpu_rsp_valid, fpu_rsp_tag, fpu_rsp_result, fpu_rsp_fflags, x_result_ready,
    input x_issue_ready, fpu_req_valid, fpu_req_tag, fpu_req_op, fpu_req_op_mod, fpu_req_fmt, fpu_req_rm,
    input fpu_req_rs, fpu_rsp_ready, x_result_valid, x_result_id, x_result_data, x_result_fflags, busy
  );
endinterface

// File: rtl/cv32e40p_fpu_xif_result_reg.sv
// cv32e40p_fpu_xif_result_reg: one-entry valid/ready register holding an FPU result for the X-IF
module cv32e40p_fpu_xif_result_reg
  import cv32e40p_fpu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rsp_valid,
  output logic rsp_ready,
  input  fpu_xif_result_t rsp_data,
  output logic res_valid,
  input  logic res_ready,
  output fpu_xif_result_t res_data
);
  assign rsp_ready = !res_valid || res_ready;
  // Load on response handshake; drop valid once the consumer takes it without a replacement
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      res_valid <= 1'b0;
      res_data <= '0;
    end else if (rsp_valid && rsp_ready) begin
      res_valid <= 1'b1;
      res_data <= rsp_data;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
endmodule

// File: rtl/cv32e40p_fpu_xif_buffer.sv
// cv32e40p_fpu_xif_buffer: holds issued FP ops until commit, dispatches them in order to the FPU
module cv32e40p_fpu_xif_buffer
  import cv32e40p_fpu_pkg::*;
#(
  parameter int DEPTH = C_DEPTH,
  parameter int MAX_OUTSTANDING = C_MAX_OUTSTANDING
) (
  input logic clk_i,
  input logic rst_ni,
  cv32e40p_fpu_xif_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  fpu_xif_entry_t mem_q [DEPTH];
  fpu_xif_entry_t head, new_entry;
  fpu_xif_result_t rsp, res;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [DEPTH-1:0] live;
  logic push, pop, head_live, req_fire, rsp_fire, new_hit;
  for (genvar g = 0; g < DEPTH; g++) begin : g_live
    assign live[g] = {1'b0, PW'(g) - rd_ptr} < count;
  end
  assign head = mem_q[rd_ptr];
  assign head_live = count != '0;
  assign bus.x_issue_ready = count < CW'(DEPTH);
  assign push = bus.x_issue_valid && bus.x_issue_ready;
  assign bus.fpu_req_valid = head_live && head.committed && !head.killed
                             && outstanding < OW'(MAX_OUTSTANDING);
  assign req_fire = bus.fpu_req_valid && bus.fpu_req_ready;
  assign rsp_fire = bus.fpu_rsp_valid && bus.fpu_rsp_ready;
  assign pop = (head_live && head.killed) || req_fire;
  assign new_hit = bus.x_commit_valid && bus.x_commit_id == bus.x_issue_id;
  // Request fields are forced to zero while idle so the FPU never sees stale storage
  assign bus.fpu_req_tag = bus.fpu_req_valid ? head.id : '0;
  assign bus.fpu_req_op = bus.fpu_req_valid ? head.op : '0;
  assign bus.fpu_req_op_mod = bus.fpu_req_valid && head.op_mod;
  assign bus.fpu_req_fmt = bus.fpu_req_valid ? head.fmt : '0;
  assign bus.fpu_req_rm = bus.fpu_req_valid ? head.rm : '0;
  assign bus.fpu_req_rs = bus.fpu_req_valid ? head.rs : '0;
  assign bus.busy = head_live || outstanding != '0 || bus.x_result_valid;
  // New entry picks up a commit for its own id arriving in the same cycle
  always_comb begin
    new_entry = '{id: bus.x_issue_id, op: bus.x_issue_op, op_mod: bus.x_issue_op_mod,
                  fmt: bus.x_issue_fmt, rm: bus.x_issue_rm, rs: bus.x_issue_rs,
                  committed: new_hit, killed: new_hit && bus.x_commit_kill};
  end
  // Entry storage: write on push, mark commit/kill on live entries matching the commit id
  always_ff @(posedge clk_i)
    for (int i = 0; i < DEPTH; i++)
      if (push && wr_ptr == PW'(i)) mem_q[i] <= new_entry;
      else if (live[i] && bus.x_commit_valid && mem_q[i].id == bus.x_commit_id) begin
        mem_q[i].committed <= 1'b1;
        mem_q[i].killed <= bus.x_commit_kill;
      end
  // Pointers, occupancy and in-flight count
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      outstanding <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + OW'(req_fire) - OW'(rsp_fire);
    end
  assign rsp = '{id: bus.fpu_rsp_tag, data: bus.fpu_rsp_result, fflags: bus.fpu_rsp_fflags};
  cv32e40p_fpu_xif_result_reg u_result (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .rsp_valid(bus.fpu_rsp_valid),
    .rsp_ready(bus.fpu_rsp_ready),
    .rsp_data(rsp),
    .res_valid(bus.x_result_valid),
    .res_ready(bus.x_result_ready),
    .res_data(res)
  );
  assign bus.x_result_id = res.id;
  assign bus.x_result_data = res.data;
  assign bus.x_result_fflags = res.fflags;
endmodule

// File: tb/tb_cv32e40p_fpu_xif_buffer.sv
// tb_cv32e40p_fpu_xif_buffer: directed scoreboard bench for the FPU X-IF buffer
module tb_cv32e40p_fpu_xif_buffer;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int tests = 0;
  int fails = 0;
  int n_req = 0;
  int base;
  bit rsp_fired;
  logic [3:0] exp_tag_q[$];
  logic [3:0] inflight_q[$];
  logic [40:0] exp_res_q[$];
  cv32e40p_fpu_xif_buffer_if bus();
  cv32e40p_fpu_xif_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // Compare one observed value to its expectation and count the outcome
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] rs0_of(input logic [3:0] t);
    return 32'h1000_0000 | 32'(t);
  endfunction
  // Sample handshakes mid-cycle against the scoreboards, then advance one clock
  task automatic tick();
    logic [3:0] t;
    logic [40:0] r;
    #1;
    if (bus.fpu_req_valid && bus.fpu_req_ready) begin
      n_req++;
      if (exp_tag_q.size() == 0) check("req_unexpected", 64'(bus.fpu_req_tag), 64'hdead);
      else begin
        t = exp_tag_q.pop_front();
        check("req_tag", 64'(bus.fpu_req_tag), 64'(t));
        check("req_op", 64'(bus.fpu_req_op), 64'(t));
        check("req_rs0", 64'(bus.fpu_req_rs[0]), 64'(rs0_of(t)));
        inflight_q.push_back(t);
      end
    end
    if (bus.fpu_rsp_valid && bus.fpu_rsp_ready) begin
      rsp_fired = 1'b1;
      exp_res_q.push_back({bus.fpu_rsp_tag, bus.fpu_rsp_result, bus.fpu_rsp_fflags});
    end
    if (bus.x_result_valid && bus.x_result_ready) begin
      if (exp_res_q.size() == 0) check("res_unexpected", 64'(bus.x_result_id), 64'hdead);
      else begin
        r = exp_res_q.pop_front();
        check("result", 64'({bus.x_result_id, bus.x_result_data, bus.x_result_fflags}), 64'(r));
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] id, input bit commit);
    bus.x_issue_valid = 1'b1;
    bus.x_issue_id = id;
    bus.x_issue_op = id;
    bus.x_issue_op_mod = id[0];
    bus.x_issue_fmt = id[2:0];
    bus.x_issue_rm = ~id[2:0];
    bus.x_issue_rs = {32'h3000_0000 | 32'(id), 32'h2000_0000 | 32'(id), rs0_of(id)};
    bus.x_commit_valid = commit;
    bus.x_commit_id = id;
    bus.x_commit_kill = 1'b0;
    if (commit) exp_tag_q.push_back(id);
  endtask
  task automatic commit(input logic [3:0] id, input bit kill);
    bus.x_commit_valid = 1'b1;
    bus.x_commit_id = id;
    bus.x_commit_kill = kill;
    if (!kill) exp_tag_q.push_back(id);
  endtask
  task automatic idle();
    bus.x_issue_valid = 1'b0;
    bus.x_commit_valid = 1'b0;
    bus.x_commit_kill = 1'b0;
  endtask
  task automatic drive_rsp(input logic [31:0] data, input logic [4:0] ff);
    bus.fpu_rsp_valid = 1'b1;
    bus.fpu_rsp_tag = inflight_q.size() != 0 ? inflight_q.pop_front() : 4'hf;
    bus.fpu_rsp_result = data;
    bus.fpu_rsp_fflags = ff;
  endtask
  // Present a response for the oldest in-flight op and hold it until accepted
  task automatic send_rsp(input logic [31:0] data, input logic [4:0] ff);
    drive_rsp(data, ff);
    rsp_fired = 1'b0;
    for (int k = 0; k < 20 && !rsp_fired; k++) tick();
    if (!rsp_fired) check("rsp_timeout", 64'(bus.fpu_rsp_ready), 64'd1);
    bus.fpu_rsp_valid = 1'b0;
  endtask
  initial begin
    idle();
    bus.x_issue_id = '0;
    bus.x_issue_op = '0;
    bus.x_issue_op_mod = 1'b0;
    bus.x_issue_fmt = '0;
    bus.x_issue_rm = '0;
    bus.x_issue_rs = '0;
    bus.x_commit_id = '0;
    bus.fpu_req_ready = 1'b1;
    bus.fpu_rsp_valid = 1'b0;
    bus.fpu_rsp_tag = '0;
    bus.fpu_rsp_result = '0;
    bus.fpu_rsp_fflags = '0;
    bus.x_result_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 64'(bus.fpu_req_valid), 64'd0);
    check("rst_outputs", 64'({bus.x_result_valid, bus.fpu_rsp_ready, bus.x_issue_ready, bus.busy}), 64'b0110);
    check("rst_data", 64'({bus.x_result_data, bus.x_result_id, bus.fpu_req_tag}), 64'd0);
    rst_ni = 1'b1;
    // Issue and commit id 3 together; result 0x3F800000 / fflags 1
    issue(4'd3, 1'b1);
    tick();
    idle();
    check("t1_req_valid", 64'(bus.fpu_req_valid), 64'd1);
    check("t1_req_tag", 64'(bus.fpu_req_tag), 64'd3);
    tick();
    send_rsp(32'h3F80_0000, 5'b00001);
    check("t1_res_valid", 64'(bus.x_result_valid), 64'd1);
    check("t1_res", 64'({bus.x_result_id, bus.x_result_data, bus.x_result_fflags}), 64'({4'd3, 32'h3F80_0000, 5'd1}));
    tick();
    check("t1_busy", 64'(bus.busy), 64'd0);
    // Kill id 2 between committed ids 1 and 3
    issue(4'd1, 1'b0);
    tick();
    issue(4'd2, 1'b0);
    tick();
    issue(4'd3, 1'b0);
    tick();
    idle();
    commit(4'd2, 1'b1);
    tick();
    idle();
    check("t2_no_req", 64'(bus.fpu_req_valid), 64'd0);
    commit(4'd1, 1'b0);
    tick();
    commit(4'd3, 1'b0);
    tick();
    idle();
    check("t2_killed_head", 64'(bus.fpu_req_valid), 64'd0);
    tick();
    check("t2_req3", 64'({bus.fpu_req_valid, bus.fpu_req_tag}), 64'({1'b1, 4'd3}));
    tick();
    send_rsp(32'h1111_0001, 5'd2);
    send_rsp(32'h1111_0003, 5'd4);
    check("t2_busy_before", 64'(bus.busy), 64'd1);
    tick();
    check("t2_busy_after", 64'(bus.busy), 64'd0);
    // Fill the buffer, then free one slot by a commit-and-dispatch
    for (int i = 0; i < 5; i++) begin
      issue(4'(4 + i), 1'b0);
      check("t3_issue_ready", 64'(bus.x_issue_ready), 64'(i < 4));
      tick();
    end
    commit(4'd4, 1'b0);
    tick();
    bus.x_commit_valid = 1'b0;
    check("t3_full_pop", 64'({bus.fpu_req_valid, bus.x_issue_ready}), 64'b10);
    tick();
    check("t3_freed", 64'(bus.x_issue_ready), 64'd1);
    tick();
    idle();
    for (int i = 5; i < 8; i++) begin
      commit(4'(i), 1'b1);
      tick();
    end
    commit(4'd8, 1'b0);
    tick();
    idle();
    repeat (6) tick();
    check("t3_drained", 64'(n_req), 64'd5);
    send_rsp(32'h2222_0004, 5'd0);
    send_rsp(32'h2222_0008, 5'd8);
    tick();
    check("t3_busy", 64'(bus.busy), 64'd0);
    // In-flight limit of two with withheld responses
    base = n_req;
    issue(4'd9, 1'b1);
    tick();
    issue(4'd10, 1'b1);
    tick();
    issue(4'd11, 1'b1);
    tick();
    idle();
    repeat (4) tick();
    check("t4_two_sent", 64'(n_req - base), 64'd2);
    check("t4_blocked", 64'(bus.fpu_req_valid), 64'd0);
    drive_rsp(32'h3333_0009, 5'd1);
    check("t4_blocked_rsp_cycle", 64'(bus.fpu_req_valid), 64'd0);
    tick();
    bus.fpu_rsp_valid = 1'b0;
    check("t4_third", 64'({bus.fpu_req_valid, bus.fpu_req_tag}), 64'({1'b1, 4'd11}));
    tick();
    send_rsp(32'h3333_000a, 5'd2);
    send_rsp(32'h3333_000b, 5'd3);
    tick();
    check("t4_busy", 64'(bus.busy), 64'd0);
    // Result back-pressure with two responses
    bus.x_result_ready = 1'b0;
    issue(4'd12, 1'b1);
    tick();
    issue(4'd13, 1'b1);
    tick();
    idle();
    repeat (2) tick();
    drive_rsp(32'h4444_000c, 5'd5);
    tick();
    drive_rsp(32'h4444_000d, 5'd6);
    check("t5_rsp_ready_low", 64'(bus.fpu_rsp_ready), 64'd0);
    check("t5_held", 64'({bus.x_result_valid, bus.x_result_id, bus.x_result_data}), 64'({1'b1, 4'd12, 32'h4444_000c}));
    repeat (2) tick();
    check("t5_stable", 64'({bus.x_result_valid, bus.x_result_id, bus.x_result_data, bus.x_result_fflags}),
          64'({1'b1, 4'd12, 32'h4444_000c, 5'd5}));
    bus.x_result_ready = 1'b1;
    tick();
    bus.fpu_rsp_valid = 1'b0;
    check("t5_second", 64'({bus.x_result_valid, bus.x_result_id}), 64'({1'b1, 4'd13}));
    tick();
    check("t5_busy", 64'(bus.busy), 64'd0);
    // Reset with three buffered entries and one in flight
    issue(4'd14, 1'b1);
    tick();
    issue(4'd15, 1'b0);
    tick();
    issue(4'd1, 1'b0);
    tick();
    issue(4'd2, 1'b0);
    tick();
    idle();
    check("t6_busy_pre", 64'({bus.busy, bus.x_issue_ready}), 64'b11);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_rst_outputs", 64'({bus.fpu_req_valid, bus.x_result_valid, bus.fpu_rsp_ready, bus.x_issue_ready, bus.busy}),
          64'b00110);
    exp_tag_q.delete();
    inflight_q.delete();
    @(posedge clk);
    #1 rst_ni = 1'b1;
    issue(4'd0, 1'b1);
    tick();
    issue(4'd3, 1'b1);
    tick();
    idle();
    check("t6_second_req", 64'({bus.fpu_req_valid, bus.fpu_req_tag}), 64'({1'b1, 4'd3}));
    tick();
    send_rsp(32'h5555_0000, 5'd0);
    send_rsp(32'h5555_0003, 5'd1);
    tick();
    check("t6_busy", 64'(bus.busy), 64'd0);
    check("sb_tags_empty", 64'(exp_tag_q.size()), 64'd0);
    check("sb_results_empty", 64'(exp_res_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
